tempo_generator_mc: RTL and testbench
=====================================

Name: tempo_generator_mc

Overview:
Multi-channel, parametrised successor to the single-channel AXI4-Lite tempo generator in the AudSynth datapath. Provides NUM_CH independent beat clocks. Each channel has a programmable period in ACLK cycles and a programmable beats-per-bar. Each channel emits one-cycle tick and bar pulses to the sequencer/voice logic and exposes its live beat position over AXI4-Lite.

Parameters:
NUM_CH, 4, number of tempo channels (1..14)
CNT_W, 32, period counter width in bits (1..32)
DEF_PERIOD, 12500000, reset value of every PERIOD register (truncated to CNT_W)
DEF_BEATS, 4, reset value of every BEATS register (8 bits)
C_S_AXI_ADDR_WIDTH, 8, AXI4-Lite address width (data width fixed at 32)

Ports:
ACLK  in  1  sole clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
tick  out  NUM_CH  per-channel one-cycle beat pulse
bar  out  NUM_CH  per-channel one-cycle bar-start pulse
beat_pos  out  8*NUM_CH  per-channel current beat index, channel i at [8i+7:8i]

Behaviour:
- Reset (ARESETN low, asynchronous):
  - All AXI valid/ready outputs, RDATA, tick, bar, beat_pos, counters and CTRL are 0.
  - PERIOD = DEF_PERIOD; BEATS = DEF_BEATS.
- Register map (byte addresses, low 2 bits ignored):
  - 0x00 CTRL: bit i = channel i enable; bit 31 = RESTART, write-only, self-clearing, reads as 0.
  - 0x10+0x10*i PERIOD[i]: CNT_W bits, upper bits read 0.
  - 0x14+0x10*i BEATS[i]: bits [7:0].
  - 0x18+0x10*i BEAT_POS[i]: read-only.
  - All other addresses: writes ignored (OKAY), reads return 0.
- Write handshake:
  - AWREADY and WREADY are asserted together for exactly one cycle when AWVALID and WVALID are both high and BVALID is low.
  - The register updates on that edge, per WSTRB byte.
  - BVALID rises the next cycle and holds until BREADY.
  - Only one write is outstanding at a time.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RDATA/RVALID are registered the next cycle and held stable until RREADY.
  - A read accepted in the same cycle as a write to the same register returns the pre-write value.
- Channel counter (per channel, cnt is CNT_W bits):
  - Running means enable bit = 1 and PERIOD != 0; otherwise cnt = 0, beat_pos = 0, and tick/bar stay low.
  - While running, cnt increments each cycle.
  - When cnt >= PERIOD-1: tick pulses for one cycle, cnt goes to 0, and beat_pos goes to beat_pos+1.
  - beat_pos wraps to 0 when beat_pos+1 >= BEATS. BEATS = 0 behaves as 1.
  - bar pulses in the same cycle as a tick that wraps beat_pos to 0.
  - The first tick after enable occurs PERIOD cycles after the enabling write edge (cnt counts 0..PERIOD-1). Hence PERIOD=1 gives a tick every cycle.
- Shrinking PERIOD below the current cnt gives a tick on the next cycle (>= compare); no counter overflow.
- Shrinking BEATS below the current beat_pos wraps beat_pos to 0 on the next tick, with a bar pulse.
- RESTART: a write with bit 31 = 1 zeroes cnt and beat_pos of all channels on the same edge, so enabled channels with equal PERIOD stay phase-aligned. The enable bits in the same write apply simultaneously.
- Disabling a channel mid-count clears its state on the next edge; no further tick/bar.
- ARESETN assertion mid-transaction aborts it: the master must reissue, and no B/R response is produced.

Test Plan:
- Reset, then read 0x10/0x14/0x00 -> 12500000 (or DEF_PERIOD truncated), 4, 0; all tick/bar low.
- PERIOD[0]=5, BEATS[0]=3, CTRL=0x1 -> tick[0] at cycles 5,10,15,...; bar[0] at cycles 15,30; beat_pos[0] sequence 1,2,0.
- PERIOD[1]=4, PERIOD[2]=4 with offset enables, then write CTRL=0x80000006 -> tick[1] and tick[2] coincide 4 cycles after the write and every 4 cycles after.
- PERIOD[0]=100; at cnt=50 write PERIOD[0]=10 -> tick[0] next cycle, then every 10 cycles.
- Write 0x12345678 to PERIOD[3] with WSTRB=4'b0011 -> readback low half 0x5678, upper half unchanged. Write to 0xFC -> OKAY, reads 0.
- Hold AWVALID high, delay WVALID 3 cycles and BREADY 2 cycles -> single AW/W accept when both valid; BVALID held until BREADY; no second write accepted meanwhile.

Source files
------------

// File: rtl/tempo_generator_mc.sv
// Multi-channel tempo generator: NUM_CH independent beat clocks with tick/bar pulses,
// each channel's period, beats-per-bar and live beat position exposed over AXI4-Lite.
module tempo_generator_mc #(
  parameter int NUM_CH             = 4,
  parameter int CNT_W              = 32,
  parameter int DEF_PERIOD         = 12500000,
  parameter int DEF_BEATS          = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             bar,
  output logic [8*NUM_CH-1:0]           beat_pos
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic              r_awready, r_bvalid, r_arready, r_rvalid;
  logic [31:0]       r_rdata;
  logic [NUM_CH-1:0] r_en;
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [7:0]        r_beats  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [7:0]        r_bp     [NUM_CH];
  logic [NUM_CH-1:0] r_tick, r_bar;

  logic [AW-3:0]     w_wr_word, w_rd_word;
  logic              w_wr_fire, w_rd_fire, w_restart;
  logic [31:0]       w_ctrl_new, w_rd_data;
  logic [NUM_CH-1:0] w_run, w_wrap;
  logic              w_unused;

  // Valid/ready: a channel transfers on a rising ACLK edge where both are high;
  // responses hold valid and payload stable until the matching ready is seen.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++)
      if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  assign w_wr_word  = S_AXI_AWADDR[AW-1:2];
  assign w_rd_word  = S_AXI_ARADDR[AW-1:2];
  assign w_wr_fire  = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_fire  = r_arready & S_AXI_ARVALID;
  assign w_ctrl_new = merge({{(32-NUM_CH){1'b0}}, r_en}, S_AXI_WDATA, S_AXI_WSTRB);
  assign w_restart  = w_wr_fire & (w_wr_word == '0) & S_AXI_WDATA[31] & S_AXI_WSTRB[3];
  assign w_unused   = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], w_ctrl_new[31:NUM_CH]};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign tick          = r_tick;
  assign bar           = r_bar;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign beat_pos[8*g +: 8] = r_bp[g];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_en      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_period[i] <= CNT_W'(DEF_PERIOD);
        r_beats[i]  <= 8'(DEF_BEATS);
      end
    end else begin
      r_awready <= S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid & ~r_awready;
      if (w_wr_fire) r_bvalid <= 1'b1;
      else if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
      if (w_wr_fire && w_wr_word == '0) r_en <= w_ctrl_new[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_fire && int'(w_wr_word) == 4 + 4*i)
          r_period[i] <= CNT_W'(merge(32'(r_period[i]), S_AXI_WDATA, S_AXI_WSTRB));
        if (w_wr_fire && int'(w_wr_word) == 5 + 4*i && S_AXI_WSTRB[0])
          r_beats[i] <= S_AXI_WDATA[7:0];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_word == '0) w_rd_data[NUM_CH-1:0] = r_en;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(w_rd_word) == 4 + 4*i) w_rd_data = 32'(r_period[i]);
      if (int'(w_rd_word) == 5 + 4*i) w_rd_data = {24'd0, r_beats[i]};
      if (int'(w_rd_word) == 6 + 4*i) w_rd_data = {24'd0, r_bp[i]};
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= S_AXI_ARVALID & ~r_rvalid & ~r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // BEATS of 0 is treated as 1, so every tick is then also a bar.
  always_comb begin
    w_run  = '0;
    w_wrap = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_run[i]  = r_en[i] && (r_period[i] != '0);
      w_wrap[i] = ({1'b0, r_bp[i]} + 9'd1) >= ((r_beats[i] == 8'd0) ? 9'd1 : {1'b0, r_beats[i]});
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_tick <= '0;
      r_bar  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_bp[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_restart || !w_run[i]) begin
          r_cnt[i]  <= '0;
          r_bp[i]   <= '0;
          r_tick[i] <= 1'b0;
          r_bar[i]  <= 1'b0;
        end else if (r_cnt[i] >= r_period[i] - CNT_W'(1)) begin
          r_cnt[i]  <= '0;
          r_tick[i] <= 1'b1;
          r_bar[i]  <= w_wrap[i];
          r_bp[i]   <= w_wrap[i] ? 8'd0 : r_bp[i] + 8'd1;
        end else begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_tick[i] <= 1'b0;
          r_bar[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tempo_generator_mc.sv
// Bench for tempo_generator_mc: directed and random AXI traffic checked every cycle
// against an elapsed-time model of each beat clock plus a read-data scoreboard.
module tb_tempo_generator_mc;

  localparam int NUM_CH = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [7:0]  S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [7:0]  S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [NUM_CH-1:0]   tick, bar;
  logic [8*NUM_CH-1:0] beat_pos;

  int checks = 0;
  int failures = 0;

  tempo_generator_mc #(.NUM_CH(NUM_CH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .tick(tick), .bar(bar), .beat_pos(beat_pos)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: a channel ticks once PERIOD edges have elapsed since its last
  // tick, restart, or the last edge on which it was idle
  logic [NUM_CH-1:0] m_en;
  logic [31:0]       m_per   [NUM_CH];
  logic [7:0]        m_beats [NUM_CH];
  logic [7:0]        m_bp    [NUM_CH];
  int                m_last  [NUM_CH];
  int                m_cyc;
  logic [NUM_CH-1:0] e_tick, e_bar;
  logic [31:0]       exp_q[$];

  function automatic logic [31:0] model_read(input logic [7:0] a);
    logic [31:0] r;
    int ch, sub;
    r = '0;
    ch = int'(a >> 4) - 1;
    sub = int'((a >> 2) & 8'd3);
    if ((a >> 2) == 8'd0) r[NUM_CH-1:0] = m_en;
    else if (a >= 8'h10 && ch < NUM_CH) begin
      if (sub == 0) r = m_per[ch];
      else if (sub == 1) r = {24'd0, m_beats[ch]};
      else if (sub == 2) r = {24'd0, m_bp[ch]};
    end
    return r;
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin : model
    logic wf, rs;
    logic [31:0] v;
    int a, ch, sub, eff, el;
    if (!ARESETN) begin
      m_en <= '0;
      e_tick <= '0;
      e_bar <= '0;
      m_cyc <= 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_per[i] <= 32'd12500000;
        m_beats[i] <= 8'd4;
        m_bp[i] <= 8'd0;
        m_last[i] <= 0;
      end
    end else begin
      wf = S_AXI_AWVALID && S_AXI_AWREADY && S_AXI_WVALID && S_AXI_WREADY;
      a = int'(S_AXI_AWADDR);
      rs = wf && (a >> 2) == 0 && S_AXI_WDATA[31] && S_AXI_WSTRB[3];
      m_cyc <= m_cyc + 1;
      if (S_AXI_ARVALID && S_AXI_ARREADY) exp_q.push_back(model_read(S_AXI_ARADDR));
      for (int i = 0; i < NUM_CH; i++) begin
        el = m_cyc - m_last[i];
        eff = (m_beats[i] == 8'd0) ? 1 : int'(m_beats[i]);
        if (rs || !(m_en[i] && m_per[i] != 0)) begin
          m_last[i] <= m_cyc;
          m_bp[i] <= 8'd0;
          e_tick[i] <= 1'b0;
          e_bar[i] <= 1'b0;
        end else if (32'(el) >= m_per[i]) begin
          m_last[i] <= m_cyc;
          e_tick[i] <= 1'b1;
          e_bar[i] <= (int'(m_bp[i]) + 1 >= eff);
          m_bp[i] <= (int'(m_bp[i]) + 1 >= eff) ? 8'd0 : m_bp[i] + 8'd1;
        end else begin
          e_tick[i] <= 1'b0;
          e_bar[i] <= 1'b0;
        end
      end
      if (wf) begin
        ch = (a >> 4) - 1;
        sub = (a >> 2) & 3;
        if ((a >> 2) == 0) begin
          v = {28'd0, m_en};
          for (int b = 0; b < 4; b++) if (S_AXI_WSTRB[b]) v[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
          m_en <= v[NUM_CH-1:0];
        end else if (a >= 16 && ch < NUM_CH) begin
          if (sub == 0) begin
            v = m_per[ch];
            for (int b = 0; b < 4; b++) if (S_AXI_WSTRB[b]) v[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            m_per[ch] <= v;
          end else if (sub == 1 && S_AXI_WSTRB[0]) begin
            m_beats[ch] <= S_AXI_WDATA[7:0];
          end
        end
      end
    end
  end

  // per-cycle comparison of the beat outputs
  always @(negedge ACLK) begin : mon
    logic [8*NUM_CH-1:0] ebp;
    for (int i = 0; i < NUM_CH; i++) ebp[8*i +: 8] = m_bp[i];
    chk("tick", 64'(tick), 64'(e_tick));
    chk("bar", 64'(bar), 64'(e_bar));
    chk("beat_pos", 64'(beat_pos), 64'(ebp));
  end

  // driver tasks
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("awready", 64'(S_AXI_AWREADY), 64'd1);
    chk("wready", 64'(S_AXI_WREADY), 64'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("bvalid", 64'(S_AXI_BVALID), 64'd1);
    chk("bresp", 64'(S_AXI_BRESP), 64'd0);
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clr", 64'(S_AXI_BVALID), 64'd0);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int hold);
    int n;
    logic [31:0] e;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    chk("arready", 64'(S_AXI_ARREADY), 64'd1);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge ACLK);
      chk("rvalid", 64'(S_AXI_RVALID), 64'd1);
      chk($sformatf("rdata@%0h", addr), 64'(S_AXI_RDATA), 64'(e));
    end
    chk("rresp", 64'(S_AXI_RRESP), 64'd0);
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    chk("rvalid_clr", 64'(S_AXI_RVALID), 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  initial begin
    logic [7:0] ra;
    logic [31:0] e;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
    chk("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    chk("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    chk("rst_rdata", 64'(S_AXI_RDATA), 64'd0);
    ARESETN = 1'b1;

    axi_read(8'h10, 0);
    axi_read(8'h14, 0);
    axi_read(8'h00, 0);

    axi_write(8'h10, 32'd5, 4'hF);
    axi_write(8'h14, 32'd3, 4'hF);
    axi_write(8'h00, 32'h1, 4'hF);
    idle(35);
    axi_read(8'h18, 2);

    axi_write(8'h20, 32'd4, 4'hF);
    axi_write(8'h30, 32'd4, 4'hF);
    axi_write(8'h00, 32'h3, 4'hF);
    idle(1);
    axi_write(8'h00, 32'h7, 4'hF);
    idle(5);
    axi_write(8'h00, 32'h8000_0006, 4'hF);
    idle(20);

    axi_write(8'h10, 32'd100, 4'hF);
    axi_write(8'h00, 32'h8000_0001, 4'hF);
    idle(45);
    axi_write(8'h10, 32'd10, 4'hF);
    idle(30);

    axi_write(8'h40, 32'h1234_5678, 4'b0011);
    axi_read(8'h40, 0);
    axi_write(8'hFC, 32'hFFFF_FFFF, 4'hF);
    axi_read(8'hFC, 0);
    axi_read(8'h04, 0);

    // AW waits for a late W; B is held while valids stay up
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h14; S_AXI_WDATA = 32'd5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
    repeat (3) begin
      @(negedge ACLK);
      chk("aw_wait_w", 64'(S_AXI_AWREADY), 64'd0);
    end
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    chk("aw_accept", 64'(S_AXI_AWREADY & S_AXI_WREADY), 64'd1);
    S_AXI_WDATA = 32'd2;
    repeat (2) begin
      @(negedge ACLK);
      chk("no_second_aw", 64'(S_AXI_AWREADY), 64'd0);
      chk("b_held", 64'(S_AXI_BVALID), 64'd1);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    chk("b_done", 64'(S_AXI_BVALID), 64'd0);
    axi_read(8'h14, 0);

    // read and write of BEATS[1] accepted on the same edge
    @(negedge ACLK);
    S_AXI_AWADDR = 8'h24; S_AXI_WDATA = 32'd7; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 8'h24; S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    chk("rw_awready", 64'(S_AXI_AWREADY), 64'd1);
    chk("rw_arready", 64'(S_AXI_ARREADY), 64'd1);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk("rw_rdata_old", 64'(S_AXI_RDATA), 64'(e));
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    axi_read(8'h24, 0);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: axi_write(8'(16 + 16 * $urandom_range(0, NUM_CH - 1)), 32'($urandom_range(0, 9)),
                     ($urandom_range(0, 3) == 0) ? 4'b0001 : 4'hF);
        1: axi_write(8'(20 + 16 * $urandom_range(0, NUM_CH - 1)), 32'($urandom_range(0, 5)), 4'hF);
        2: axi_write(8'h00, {($urandom_range(0, 3) == 0), 27'd0, 4'($urandom_range(0, 15))}, 4'hF);
        default: begin
          ra = 8'(4 * $urandom_range(0, 63));
          axi_read(ra, $urandom_range(0, 2));
        end
      endcase
      idle($urandom_range(0, 15));
    end

    // asynchronous reset while channels run
    axi_write(8'h10, 32'd1, 4'hF);
    axi_write(8'h00, 32'hF, 4'hF);
    idle(3);
    #2 ARESETN = 1'b0;
    #1;
    chk("arst_tick", 64'(tick), 64'd0);
    chk("arst_beat_pos", 64'(beat_pos), 64'd0);
    idle(2);
    ARESETN = 1'b1;
    axi_read(8'h00, 0);
    axi_read(8'h10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
